// File: rtl/perf_monitor.sv
// perf_monitor: configurable multi-channel event counter block.
// Each channel counts one selected event strobe in level or rising-edge mode,
// wraps or saturates at full scale with a sticky overflow flag, and is read
// only through a snapshot bank that captures every channel at once.
// The event strobe port is called "events" because "event" is a reserved word.
module perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int EVT_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SEL_W = (EVT_W > 1) ? $clog2(EVT_W) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [EVT_W-1:0]  events,
  input  logic              run,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [2:0]        cfg_mode,
  input  logic              snap_req,
  output logic              snap_valid,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);

  // Bit positions inside the per-channel mode field.
  localparam int MODE_EN   = 0;
  localparam int MODE_EDGE = 1;
  localparam int MODE_SAT  = 2;

  // Mode loaded at reset: enabled, level sensitive, wrapping.
  localparam logic [2:0] MODE_DEFAULT = 3'b001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-channel configuration and state.
  logic [SEL_W-1:0]  sel_q   [NUM_CH];
  logic [2:0]        mode_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_q  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;

  // Previous sample of every event line, used for rising-edge detection.
  logic [EVT_W-1:0]  evt_prev_q;
  logic              snap_valid_q;

  // Per-channel decode results.
  logic [NUM_CH-1:0] evt_cur;
  logic [NUM_CH-1:0] evt_old;
  logic [NUM_CH-1:0] sel_ok;
  logic [NUM_CH-1:0] qual;
  logic [NUM_CH-1:0] inc;

  // Route the selected event (current and previous sample) to each channel
  // and decide whether that channel increments at the coming edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    evt_cur = '0;
    evt_old = '0;
    sel_ok  = '0;
    qual    = '0;
    inc     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int e = 0; e < EVT_W; e++) begin
        if (sel_q[ch] == SEL_W'(e)) begin
          evt_cur[ch] = events[e];
          evt_old[ch] = evt_prev_q[e];
        end
      end
      // A select pointing past the last event line never qualifies.
      sel_ok[ch] = (32'(sel_q[ch]) < EVT_W);
      qual[ch]   = mode_q[ch][MODE_EDGE] ? (evt_cur[ch] & ~evt_old[ch])
                                         : evt_cur[ch];
      inc[ch]    = run & mode_q[ch][MODE_EN] & sel_ok[ch] & qual[ch];
    end
  end

  // Configuration, live counters and sticky overflow flags.
  // Priority per channel: reset, then a config write to this channel, then
  // clear, then the increment.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: these arrays are explicitly cleared because their reset value
      // is architecturally visible (counts, config defaults, snapshots).
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sel_q[ch]  <= SEL_W'(ch % EVT_W);
        mode_q[ch] <= MODE_DEFAULT;
        cnt_q[ch]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cfg_we && (cfg_ch == CH_W'(ch))) begin
          // A write to an address past the last channel matches nothing.
          sel_q[ch]  <= cfg_sel;
          mode_q[ch] <= cfg_mode;
          cnt_q[ch]  <= '0;
          ovf_q[ch]  <= 1'b0;
        end else if (clear) begin
          cnt_q[ch]  <= '0;
          ovf_q[ch]  <= 1'b0;
        end else if (inc[ch]) begin
          if (cnt_q[ch] == CNT_MAX) begin
            ovf_q[ch] <= 1'b1;
            if (!mode_q[ch][MODE_SAT]) begin
              cnt_q[ch] <= '0;
            end
          end else begin
            cnt_q[ch] <= cnt_q[ch] + 1'b1;
          end
        end
      end
    end
  end

  // Snapshot bank: captures the pre-edge counts, so the increment of the
  // request cycle (and a coincident clear) is not reflected.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        snap_q[ch] <= '0;
      end
    end else if (snap_req) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        snap_q[ch] <= cnt_q[ch];
      end
    end
  end

  // Edge-detect history runs every cycle, independent of run, clear and
  // configuration, so a mode change never sees a stale sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_prev_q <= '0;
    end else begin
      evt_prev_q <= events;
    end
  end

  // One pulse per accepted snapshot request, one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap_req;
    end
  end

  // Snapshot read mux; an out-of-range channel reads as zero.
  always_comb begin
    rd_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_ch == CH_W'(ch)) begin
        rd_data = snap_q[ch];
      end
    end
  end

  assign snap_valid = snap_valid_q;
  assign ovf        = ovf_q;

endmodule
